// File: rtl/amp_sweep_pkg.sv
// Shared types for the amplitude sweep controller: mode codes,
// FSM state encodings and level limits.
package amp_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_UP       = 2'b01,
    MODE_DOWN     = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DWELL = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] LVL_MIN = 2'd0;
  localparam logic [1:0] LVL_MAX = 2'd3;

  // Level taken on the start edge of a run.
  function automatic logic [1:0] first_level(
    input mode_e      m,
    input logic [1:0] hold
  );
    logic [1:0] lvl;
    lvl = LVL_MIN;
    unique case (m)
      MODE_HOLD:     lvl = hold;
      MODE_UP:       lvl = LVL_MIN;
      MODE_DOWN:     lvl = LVL_MAX;
      MODE_PINGPONG: lvl = LVL_MIN;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/amplitude_sweep_ctrl_if.sv
// Control/status bundle of the amplitude sweep controller.
// slave = controller side, master = the block driving it.
// AMP_SWEEP_IRQ_EN adds irqClr (to controller) and irq (from it).
interface amplitude_sweep_ctrl_if #(
  parameter int DWELL_W  = 16,
  parameter int SWEEPS_W = 8
);
  logic                start;
  logic                stop;
  logic [1:0]          mode;
  logic [DWELL_W-1:0]  dwell;
  logic [SWEEPS_W-1:0] sweeps;
  logic [1:0]          holdSel;
  logic [1:0]          selector;
  logic                busy;
  logic                levelStrobe;
  logic                done;
`ifdef AMP_SWEEP_IRQ_EN
  logic                irqClr;
  logic                irq;

  modport master (
    output start, stop, mode, dwell, sweeps, holdSel, irqClr,
    input  selector, busy, levelStrobe, done, irq
  );
  modport slave (
    input  start, stop, mode, dwell, sweeps, holdSel, irqClr,
    output selector, busy, levelStrobe, done, irq
  );
`else
  modport master (
    output start, stop, mode, dwell, sweeps, holdSel,
    input  selector, busy, levelStrobe, done
  );
  modport slave (
    input  start, stop, mode, dwell, sweeps, holdSel,
    output selector, busy, levelStrobe, done
  );
`endif
endinterface

// File: rtl/amp_dwell_counter.sv
// Loadable dwell down-counter; a load of 0 is clamped to 1.
// Ports: clk, rstN, load_i, en_i, value_i -> expire_o (last clk of dwell).
module amp_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] value_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (value_i == '0) ? DWELL_W'(1) : value_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count of 1 means this clk is the last one of the level.
  assign expire_o = en_i && (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/amplitude_sweep_ctrl.sv
// Sequencer stepping the amplitude selector through a sweep pattern.
// Ports: clk, rstN, bus (slave: start/stop/mode/dwell/sweeps/holdSel
// in, selector/busy/levelStrobe/done out). AMP_SWEEP_IRQ_EN adds irq.
module amplitude_sweep_ctrl
  import amp_sweep_pkg::*;
#(
  parameter int DWELL_W  = 16,
  parameter int SWEEPS_W = 8
) (
  input logic                  clk,
  input logic                  rstN,
  amplitude_sweep_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [SWEEPS_W-1:0] sweeps_q, sweeps_d;
  logic [SWEEPS_W-1:0] swcnt_q, swcnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                dir_q, dir_d;
  logic                busy_q, strb_q, strb_d, done_q;

  logic [1:0]          nxt_lvl;
  logic                nxt_dir;
  logic                sweep_end;
  logic [SWEEPS_W-1:0] swcnt_nx;
  logic                load;
  logic                expire;
  logic [DWELL_W-1:0]  load_val;

  // Start edge uses the live dwell, reloads use the latched one.
  assign load_val = (state_q == ST_IDLE) ? bus.dwell : dwell_q;

  amp_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rstN     (rstN),
    .load_i   (load),
    .en_i     (state_q == ST_DWELL),
    .value_i  (load_val),
    .expire_o (expire)
  );

  // Saturates so sweeps=0 runs never wrap.
  assign swcnt_nx = (&swcnt_q) ? swcnt_q : swcnt_q + SWEEPS_W'(1);

  always_comb begin
    nxt_lvl   = sel_q;
    nxt_dir   = dir_q;
    sweep_end = 1'b0;
    unique case (mode_q)
      MODE_HOLD: sweep_end = 1'b1;
      MODE_UP: begin
        nxt_lvl   = sel_q + 2'd1;
        sweep_end = (sel_q == LVL_MAX);
      end
      MODE_DOWN: begin
        nxt_lvl   = sel_q - 2'd1;
        sweep_end = (sel_q == LVL_MIN);
      end
      MODE_PINGPONG: begin
        if (dir_q) begin
          if (sel_q == LVL_MAX) begin
            nxt_lvl = sel_q - 2'd1;
            nxt_dir = 1'b0;
          end else begin
            nxt_lvl = sel_q + 2'd1;
          end
        end else if (sel_q == LVL_MIN + 2'd1) begin
          // Down leg ends at 1; the next sweep restarts at 0.
          nxt_lvl   = LVL_MIN;
          nxt_dir   = 1'b1;
          sweep_end = 1'b1;
        end else begin
          nxt_lvl = sel_q - 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    sweeps_d = sweeps_q;
    swcnt_d  = swcnt_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    strb_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sel_d = bus.holdSel;
        if (bus.start && !bus.stop) begin
          state_d  = ST_DWELL;
          mode_d   = mode_e'(bus.mode);
          dwell_d  = bus.dwell;
          sweeps_d = bus.sweeps;
          swcnt_d  = '0;
          dir_d    = 1'b1;
          sel_d    = first_level(mode_e'(bus.mode), bus.holdSel);
          strb_d   = 1'b1;
          load     = 1'b1;
        end
      end
      ST_DWELL: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          sel_d   = bus.holdSel;
        end else if (expire) begin
          if (sweep_end) swcnt_d = swcnt_nx;
          if (sweep_end && sweeps_q != '0 &&
              swcnt_nx == sweeps_q) begin
            state_d = ST_DONE;
            sel_d   = bus.holdSel;
          end else begin
            sel_d  = nxt_lvl;
            dir_d  = nxt_dir;
            strb_d = (mode_q != MODE_HOLD);
            load   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = bus.holdSel;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = bus.holdSel;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_HOLD;
      dwell_q  <= '0;
      sweeps_q <= '0;
      swcnt_q  <= '0;
      sel_q    <= LVL_MIN;
      dir_q    <= 1'b1;
      busy_q   <= 1'b0;
      strb_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      sweeps_q <= sweeps_d;
      swcnt_q  <= swcnt_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      busy_q   <= (state_d == ST_DWELL);
      strb_q   <= strb_d;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.selector    = sel_q;
  assign bus.busy        = busy_q;
  assign bus.levelStrobe = strb_q;
  assign bus.done        = done_q;

`ifdef AMP_SWEEP_IRQ_EN
  logic irq_q;

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)           irq_q <= 1'b0;
    else if (done_q)     irq_q <= 1'b1;
    else if (bus.irqClr) irq_q <= 1'b0;
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_amplitude_sweep_ctrl.sv
// Scoreboard bench for amplitude_sweep_ctrl.
// Expected per-clk outputs are queued at stimulus time, popped per clk.
module tb_amplitude_sweep_ctrl;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  amplitude_sweep_ctrl_if #(.DWELL_W(16), .SWEEPS_W(8)) bus ();

  amplitude_sweep_ctrl #(
    .DWELL_W  (16),
    .SWEEPS_W (8)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       strb;
    logic       done;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic b,
                      input logic st, input logic d);
    exp_t e;
    e.sel = s; e.busy = b; e.strb = st; e.done = d;
    sb.push_back(e);
  endtask

  // Expected trace from the start edge on, derived from the level pattern.
  task automatic gen(input logic [1:0] m, input int dw, input int nsw,
                     input logic [1:0] hs, input int stop_idx);
    int lv[$];
    int d_eff;
    int n;
    d_eff = (dw == 0) ? 1 : dw;
    n = 0;
    case (m)
      2'b00: lv.push_back(int'(hs));
      2'b01: for (int i = 0; i < 4; i++) lv.push_back(i);
      2'b10: for (int i = 3; i >= 0; i--) lv.push_back(i);
      default: begin
        for (int i = 0; i < 4; i++) lv.push_back(i);
        lv.push_back(2);
        lv.push_back(1);
      end
    endcase
    for (int s = 0; s < nsw; s++)
      foreach (lv[i])
        for (int d = 0; d < d_eff; d++) begin
          if (stop_idx < 0 || n <= stop_idx)
            push(2'(lv[i]), 1'b1, (d == 0) && (n == 0 || m != 2'b00), 1'b0);
          n++;
        end
    if (stop_idx >= 0) push(hs, 1'b0, 1'b0, 1'b0);
    else               push(hs, 1'b0, 1'b0, 1'b1);
    push(hs, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string nm, input exp_t e);
    chk({nm, ".sel"}, 32'(bus.selector), 32'(e.sel));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(e.busy));
    chk({nm, ".strb"}, 32'(bus.levelStrobe), 32'(e.strb));
    chk({nm, ".done"}, 32'(bus.done), 32'(e.done));
  endtask

  // Starts a run, scrambles the config and re-asserts start while busy
  // (both must be ignored), optionally stops after entry stop_idx.
  task automatic run(input string nm, input logic [1:0] m, input int dw,
                     input int sw, input logic [1:0] hs, input int nsw,
                     input int stop_idx);
    int k;
    gen(m, dw, nsw, hs, stop_idx);
    @(negedge clk);
    bus.mode = m; bus.dwell = 16'(dw); bus.sweeps = 8'(sw);
    bus.holdSel = hs; bus.start = 1'b1;
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      cmp(nm, sb.pop_front());
      if (k == 0) begin
        bus.mode = ~m; bus.dwell = 16'(dw + 5); bus.sweeps = 8'(sw + 3);
      end
      if (k == 1) bus.start = 1'b0;
      bus.stop = (k == stop_idx);
      k++;
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.mode = 0;
    bus.dwell = 0; bus.sweeps = 0; bus.holdSel = 0;
`ifdef AMP_SWEEP_IRQ_EN
    bus.irqClr = 0;
`endif
    repeat (3) @(negedge clk);
    cmp("rst0", '{sel: 2'd0, busy: 1'b0, strb: 1'b0, done: 1'b0});
    rstN = 1'b1;
    @(negedge clk);
    cmp("idle0", '{sel: 2'd0, busy: 1'b0, strb: 1'b0, done: 1'b0});

    run("up", 2'b01, 3, 2, 2'd2, 2, -1);
    run("pp", 2'b11, 1, 1, 2'd3, 1, -1);
    run("dn0", 2'b10, 0, 1, 2'd1, 1, -1);
    run("hold", 2'b00, 4, 3, 2'd1, 3, -1);

`ifdef AMP_SWEEP_IRQ_EN
    repeat (2) begin
      @(negedge clk);
      chk("irq.set", 32'(bus.irq), 32'd1);
    end
    bus.irqClr = 1'b1;
    @(negedge clk);
    bus.irqClr = 1'b0;
    chk("irq.clr", 32'(bus.irq), 32'd0);
`endif

    // up, endless run, stop on the first clk of level 2
    run("stop", 2'b01, 2, 0, 2'd3, 1, 4);

    // start and stop together in IDLE: no run
    @(negedge clk);
    bus.holdSel = 2'd3; bus.start = 1'b1; bus.stop = 1'b1;
    repeat (3) push(2'd3, 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      cmp("ss", sb.pop_front());
    end
    bus.start = 1'b0; bus.stop = 1'b0;

    // reset mid-run while selector=2
    @(negedge clk);
    bus.mode = 2'b01; bus.dwell = 16'd4; bus.sweeps = 8'd0;
    bus.holdSel = 2'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.selector != 2'd2; i++) @(negedge clk);
    chk("rst.reach", 32'(bus.selector), 32'd2);
    rstN = 1'b0;
    bus.holdSel = 2'd2;
    #1;
    cmp("rstA", '{sel: 2'd0, busy: 1'b0, strb: 1'b0, done: 1'b0});
    repeat (3) begin
      @(negedge clk);
      cmp("rstH", '{sel: 2'd0, busy: 1'b0, strb: 1'b0, done: 1'b0});
    end
    rstN = 1'b1;
    @(negedge clk);
    cmp("rstR", '{sel: 2'd2, busy: 1'b0, strb: 1'b0, done: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
